agc_tp_sequencer: RTL and testbench
===================================

Name: agc_tp_sequencer

Overview:
- Clocked sequencer that drives the NOR-gate logic built from the 74HC04/02/27 NOR-gate part models.
- Holds the gate-level `gate_rst` line asserted after power-up so NOR initial conditions settle.
- Then generates the one-hot timepulse train T01..T12 that paces each memory cycle time (MCT).
- Supports monitor stop (MSTP) and single-MCT stepping so the gate-level datapath can be run, halted and stepped from a bench or monitor model.

Parameters:
- NUM_TP, 12: timepulses per MCT; legal range 2..16.
- CYC_PER_TP, 2: clk cycles each timepulse is held; must be ≥1 and cover NOR settle time (3 gate delays of 9).
- RST_HOLD, 16: clk cycles `gate_rst` stays high after controller reset; must be ≥1.

Ports:
- clk  in  1  sequencer clock.
- rst  in  1  synchronous reset, active-low.
- run_en  in  1  level; 1 = free-run MCTs.
- mstp  in  1  level; monitor stop request, honoured at MCT boundary.
- step_req  in  1  pulse; run exactly one MCT while stopped.
- gate_rst  out  1  active-high reset to the `rst` pins of the NOR part models.
- tp  out  NUM_TP  one-hot timepulse; bit 0 = T01.
- mct_end  out  1  one-cycle pulse on the final clk of the last timepulse.
- stopped  out  1  1 while in STOP.
- mct_count  out  16  completed-MCT counter; present only with the optional feature.

Behaviour:
- Reset and register reset values:
  - rst is sampled on the clk rising edge; rst=0 forces state HOLD.
  - Reset values: hold counter = RST_HOLD-1, gate_rst=1, tp=0, mct_end=0, stopped=0, mct_count=0.
  - rst low mid-MCT aborts the MCT immediately: tp=0 next cycle, no mct_end.
- States: HOLD, STOP, RUN, STEP.
- HOLD:
  - gate_rst=1, tp=0; the hold counter decrements each cycle.
  - At counter 0 → RUN if (run_en & !mstp), else STOP.
  - gate_rst goes to 0 on the same edge that leaves HOLD.
- Timepulse generation (RUN and STEP):
  - Two internal counters: sub-cycle counter `sub` (0..CYC_PER_TP-1) and pulse index `idx` (0..NUM_TP-1).
  - tp = 1<<idx, registered.
  - On entry to RUN/STEP, the first cycle shows tp[0]=1 with sub=0.
  - `sub` wraps to 0 and `idx` increments when sub=CYC_PER_TP-1.
  - MCT length is exactly NUM_TP*CYC_PER_TP cycles.
- MCT boundary (idx=NUM_TP-1 and sub=CYC_PER_TP-1):
  - mct_end=1 for that cycle only.
  - From RUN: if mstp=1 or run_en=0 → STOP, else wrap to idx=0 with no gap cycle (back-to-back MCTs).
  - From STEP: always → STOP.
- STOP:
  - tp=0, stopped=1.
  - Exit to RUN when run_en=1 & mstp=0: tp[0] appears on the cycle after the exit condition is sampled.
  - Otherwise, step_req=1 → STEP with the same latency.
  - If both exit conditions hold, RUN wins.
- Ignored requests:
  - step_req outside STOP is dropped, not queued.
  - mstp asserted mid-MCT never truncates the MCT.
- Invariant: tp is one-hot in RUN/STEP and all-zero in HOLD/STOP; never multi-hot.
- gate_rst is 0 in every state except HOLD.

Optional Feature:
- Macro: AGC_TPSEQ_MCT_COUNT_EN.
- Defined:
  - mct_count port exists; it increments by 1 on each mct_end (RUN or STEP) and wraps 16'hFFFF→0.
  - Reset value 0; holds its value in STOP.
- Undefined: the port and its counter are absent; all other behaviour is identical.

Decomposition:
- Shared package `agc_tp_pkg` holds:
  - the state enum {HOLD, STOP, RUN, STEP};
  - the default constants NUM_TP=12, CYC_PER_TP=2, RST_HOLD=16;
  - a function for onehot(idx).
- One natural sub-module: `agc_tp_counter`, the sub/idx divider with a wrap flag.
  - Controlled by enable and clear; the top-level FSM owns the state and the boundary decisions.

Test Plan:
1. Power-up hold: rst=0 for 3 cycles, then 1, run_en=1 → gate_rst=1 for exactly 16 cycles after release, falls on the edge where tp=12'h001 appears next cycle. Each tp bit is high for 2 cycles; mct_end fires at cycle 24 of the MCT.
2. Free run: run_en=1 for 3 MCTs → 72 cycles, tp 001→002→…→800→001 with no gap, 3 mct_end pulses; mct_count=3 with the macro defined.
3. Monitor stop mid-MCT: assert mstp during T05 → MCT completes through T12, mct_end fires, then tp=0 and stopped=1 on the next cycle.
4. Single step: stopped with mstp=1, pulse step_req → exactly 24 cycles of tp, one mct_end, return to STOP. A second step_req pulsed during that MCT is ignored.
5. Reset mid-MCT: rst=0 during T07 → next cycle tp=0, gate_rst=1, no mct_end, and the 16-cycle hold restarts.
6. Parameter sweep: NUM_TP=4, CYC_PER_TP=1, RST_HOLD=1 → gate_rst high 1 cycle, MCT=4 cycles, tp 1→2→4→8, one-hot checked every cycle.

Source files
------------

// File: rtl/agc_tp_pkg.sv
// Shared types and defaults for the AGC timepulse sequencer.
// Holds the sequencer state enum, the default sizing constants and the one-hot decode helper.
package agc_tp_pkg;

  typedef enum logic [1:0] {
    HOLD = 2'd0,
    STOP = 2'd1,
    RUN  = 2'd2,
    STEP = 2'd3
  } tp_state_e;

  localparam int NUM_TP_DEF     = 12;
  localparam int CYC_PER_TP_DEF = 2;
  localparam int RST_HOLD_DEF   = 16;

  // Timepulse index to one-hot; callers truncate the result to their NUM_TP.
  function automatic logic [15:0] onehot(input logic [3:0] idx);
    onehot = 16'h0001 << idx;
  endfunction

endpackage

// File: rtl/agc_tp_counter.sv
// Sub-cycle / timepulse-index divider for the timepulse sequencer.
// Clear has priority over enable; the wrap flags mark the last sub-cycle of the last timepulse.
module agc_tp_counter
  import agc_tp_pkg::*;
#(
  parameter int NUM_TP     = NUM_TP_DEF,
  parameter int CYC_PER_TP = CYC_PER_TP_DEF
) (
  input  logic                      clk_i,
  input  logic                      rst_ni,
  input  logic                      clr_i,
  input  logic                      en_i,
  output logic [$clog2(NUM_TP)-1:0] idx_nxt_o,
  output logic                      wrap_o,
  output logic                      wrap_nxt_o
);

  localparam int IDX_W = $clog2(NUM_TP);
  localparam int SUB_W = (CYC_PER_TP > 1) ? $clog2(CYC_PER_TP) : 1;

  localparam logic [SUB_W-1:0] SUB_LAST = SUB_W'(CYC_PER_TP - 1);
  localparam logic [IDX_W-1:0] IDX_LAST = IDX_W'(NUM_TP - 1);
  localparam logic [SUB_W-1:0] SUB_ONE  = SUB_W'(1);
  localparam logic [IDX_W-1:0] IDX_ONE  = IDX_W'(1);

  logic [SUB_W-1:0] sub_q, sub_d;
  logic [IDX_W-1:0] idx_q, idx_d;

  // Next sub-cycle and timepulse index.
  always_comb begin
    sub_d = sub_q;
    idx_d = idx_q;
    if (clr_i) begin
      sub_d = {SUB_W{1'b0}};
      idx_d = {IDX_W{1'b0}};
    end else if (en_i) begin
      if (sub_q == SUB_LAST) begin
        sub_d = {SUB_W{1'b0}};
        if (idx_q == IDX_LAST) begin
          idx_d = {IDX_W{1'b0}};
        end else begin
          idx_d = idx_q + IDX_ONE;
        end
      end else begin
        sub_d = sub_q + SUB_ONE;
        idx_d = idx_q;
      end
    end else begin
      sub_d = sub_q;
      idx_d = idx_q;
    end
  end

  // Divider registers.
  always_ff @(posedge clk_i) begin
    if (!rst_ni) begin
      sub_q <= {SUB_W{1'b0}};
      idx_q <= {IDX_W{1'b0}};
    end else begin
      sub_q <= sub_d;
      idx_q <= idx_d;
    end
  end

  assign idx_nxt_o  = idx_d;
  assign wrap_o     = (sub_q == SUB_LAST) && (idx_q == IDX_LAST);
  assign wrap_nxt_o = (sub_d == SUB_LAST) && (idx_d == IDX_LAST);

endmodule

// File: rtl/agc_tp_sequencer.sv
// Timepulse sequencer: power-up gate reset hold, T01..Tn train, monitor stop and single-MCT step.
// Optional completed-MCT counter port is enabled by defining AGC_TPSEQ_MCT_COUNT_EN.
module agc_tp_sequencer
  import agc_tp_pkg::*;
#(
  parameter int NUM_TP     = NUM_TP_DEF,
  parameter int CYC_PER_TP = CYC_PER_TP_DEF,
  parameter int RST_HOLD   = RST_HOLD_DEF
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              run_en,
  input  logic              mstp,
  input  logic              step_req,
  output logic              gate_rst,
  output logic [NUM_TP-1:0] tp,
  output logic              mct_end,
`ifdef AGC_TPSEQ_MCT_COUNT_EN
  output logic              stopped,
  output logic [15:0]       mct_count
`else
  output logic              stopped
`endif
);

  localparam int HOLD_W = $clog2(RST_HOLD + 1);
  localparam int IDX_W  = $clog2(NUM_TP);

  localparam logic [HOLD_W-1:0] HOLD_INIT = HOLD_W'(RST_HOLD - 1);
  localparam logic [HOLD_W-1:0] HOLD_ONE  = HOLD_W'(1);

  tp_state_e         state_q, state_d;
  logic [HOLD_W-1:0] hold_q, hold_d;
  logic [NUM_TP-1:0] tp_q, tp_d;
  logic              gate_rst_q, gate_rst_d;
  logic              mct_end_q, mct_end_d;
  logic              stopped_q, stopped_d;
  logic              running_d;

  logic              cnt_clr_s, cnt_en_s;
  logic [IDX_W-1:0]  idx_nxt_s;
  logic              wrap_s, wrap_nxt_s;

  agc_tp_counter #(
    .NUM_TP     (NUM_TP),
    .CYC_PER_TP (CYC_PER_TP)
  ) u_counter (
    .clk_i      (clk),
    .rst_ni     (rst),
    .clr_i      (cnt_clr_s),
    .en_i       (cnt_en_s),
    .idx_nxt_o  (idx_nxt_s),
    .wrap_o     (wrap_s),
    .wrap_nxt_o (wrap_nxt_s)
  );

  // Next state and divider control; the divider sits at 0/0 whenever no MCT is in progress.
  always_comb begin
    state_d   = state_q;
    hold_d    = hold_q;
    cnt_clr_s = 1'b0;
    cnt_en_s  = 1'b0;
    case (state_q)
      HOLD: begin
        cnt_clr_s = 1'b1;
        if (hold_q == {HOLD_W{1'b0}}) begin
          if (run_en && !mstp) begin
            state_d = RUN;
          end else begin
            state_d = STOP;
          end
        end else begin
          hold_d = hold_q - HOLD_ONE;
        end
      end
      STOP: begin
        cnt_clr_s = 1'b1;
        if (run_en && !mstp) begin
          state_d = RUN;
        end else if (step_req) begin
          state_d = STEP;
        end else begin
          state_d = STOP;
        end
      end
      RUN: begin
        if (wrap_s && (mstp || !run_en)) begin
          state_d   = STOP;
          cnt_clr_s = 1'b1;
        end else begin
          cnt_en_s = 1'b1;
        end
      end
      STEP: begin
        if (wrap_s) begin
          state_d   = STOP;
          cnt_clr_s = 1'b1;
        end else begin
          cnt_en_s = 1'b1;
        end
      end
      default: begin
        state_d   = HOLD;
        cnt_clr_s = 1'b1;
      end
    endcase
  end

  // Outputs are decoded from the next state so they line up with it after the edge.
  always_comb begin
    running_d  = (state_d == RUN) || (state_d == STEP);
    tp_d       = {NUM_TP{1'b0}};
    mct_end_d  = 1'b0;
    if (running_d) begin
      tp_d      = NUM_TP'(onehot(4'(idx_nxt_s)));
      mct_end_d = wrap_nxt_s;
    end else begin
      tp_d      = {NUM_TP{1'b0}};
      mct_end_d = 1'b0;
    end
    gate_rst_d = (state_d == HOLD);
    stopped_d  = (state_d == STOP);
  end

  // State and output registers.
  always_ff @(posedge clk) begin
    if (!rst) begin
      state_q    <= HOLD;
      hold_q     <= HOLD_INIT;
      tp_q       <= {NUM_TP{1'b0}};
      gate_rst_q <= 1'b1;
      mct_end_q  <= 1'b0;
      stopped_q  <= 1'b0;
    end else begin
      state_q    <= state_d;
      hold_q     <= hold_d;
      tp_q       <= tp_d;
      gate_rst_q <= gate_rst_d;
      mct_end_q  <= mct_end_d;
      stopped_q  <= stopped_d;
    end
  end

`ifdef AGC_TPSEQ_MCT_COUNT_EN
  logic [15:0] mct_count_q;

  // Completed-MCT counter, advanced once per mct_end pulse.
  always_ff @(posedge clk) begin
    if (!rst) begin
      mct_count_q <= 16'd0;
    end else if (mct_end_q) begin
      mct_count_q <= mct_count_q + 16'd1;
    end else begin
      mct_count_q <= mct_count_q;
    end
  end

  assign mct_count = mct_count_q;
`endif

  assign gate_rst = gate_rst_q;
  assign tp       = tp_q;
  assign mct_end  = mct_end_q;
  assign stopped  = stopped_q;

endmodule

// File: tb/tb_agc_tp_sequencer.sv
// Directed self-checking bench for agc_tp_sequencer (default sizing plus a 4x1x1 instance).
module tb_agc_tp_sequencer;

  logic        clk;
  logic        rst, run_en, mstp, step_req;
  logic        gate_rst, mct_end, stopped;
  logic [11:0] tp;
  logic        rst_b, run_en_b, mstp_b, step_req_b;
  logic        gate_rst_b, mct_end_b, stopped_b;
  logic [3:0]  tp_b;
`ifdef AGC_TPSEQ_MCT_COUNT_EN
  logic [15:0] mct_count, mct_count_b;
`endif

  int checks = 0;
  int errors = 0;

  agc_tp_sequencer dut (
    .clk       (clk),
    .rst       (rst),
    .run_en    (run_en),
    .mstp      (mstp),
    .step_req  (step_req),
    .gate_rst  (gate_rst),
    .tp        (tp),
    .mct_end   (mct_end),
`ifdef AGC_TPSEQ_MCT_COUNT_EN
    .stopped   (stopped),
    .mct_count (mct_count)
`else
    .stopped   (stopped)
`endif
  );

  agc_tp_sequencer #(.NUM_TP(4), .CYC_PER_TP(1), .RST_HOLD(1)) dut_b (
    .clk       (clk),
    .rst       (rst_b),
    .run_en    (run_en_b),
    .mstp      (mstp_b),
    .step_req  (step_req_b),
    .gate_rst  (gate_rst_b),
    .tp        (tp_b),
    .mct_end   (mct_end_b),
`ifdef AGC_TPSEQ_MCT_COUNT_EN
    .stopped   (stopped_b),
    .mct_count (mct_count_b)
`else
    .stopped   (stopped_b)
`endif
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset();
    rst = 1'b0; run_en = 1'b1; mstp = 1'b0; step_req = 1'b0;
    repeat (3) tick();
    checks++; if (gate_rst !== 1'b1) begin errors++; $display("FAIL reset_gate_rst got %b want 1", gate_rst); end
    checks++; if (tp !== 12'h000) begin errors++; $display("FAIL reset_tp got %h want 000", tp); end
    checks++; if (mct_end !== 1'b0) begin errors++; $display("FAIL reset_mct_end got %b want 0", mct_end); end
    checks++; if (stopped !== 1'b0) begin errors++; $display("FAIL reset_stopped got %b want 0", stopped); end
`ifdef AGC_TPSEQ_MCT_COUNT_EN
    checks++; if (mct_count !== 16'd0) begin errors++; $display("FAIL reset_count got %0d want 0", mct_count); end
`endif
  endtask

  task automatic test_hold_release();
    int n;
    logic [11:0] exp_tp;
    n = 1;
    rst = 1'b1;
    for (int i = 0; i < 40; i++) begin
      tick();
      if (gate_rst === 1'b1) n++;
      else break;
    end
    checks++; if (n !== 16) begin errors++; $display("FAIL hold_len got %0d want 16", n); end
    for (int c = 1; c <= 24; c++) begin
      exp_tp = 12'h001 << ((c - 1) / 2);
      checks++; if (tp !== exp_tp) begin errors++; $display("FAIL mct1_tp c=%0d got %h want %h", c, tp, exp_tp); end
      checks++; if (mct_end !== (c == 24)) begin errors++; $display("FAIL mct1_end c=%0d got %b want %b", c, mct_end, c == 24); end
      tick();
    end
  endtask

  task automatic test_free_run();
    int n_end;
    logic [11:0] exp_tp;
    n_end = 0;
`ifdef AGC_TPSEQ_MCT_COUNT_EN
    checks++; if (mct_count !== 16'd1) begin errors++; $display("FAIL run_count0 got %0d want 1", mct_count); end
`endif
    for (int k = 0; k < 72; k++) begin
      exp_tp = 12'h001 << ((k % 24) / 2);
      checks++; if (tp !== exp_tp) begin errors++; $display("FAIL run_tp k=%0d got %h want %h", k, tp, exp_tp); end
      checks++; if (mct_end !== ((k % 24) == 23)) begin errors++; $display("FAIL run_end k=%0d got %b", k, mct_end); end
      if (mct_end === 1'b1) n_end++;
      tick();
    end
    checks++; if (n_end !== 3) begin errors++; $display("FAIL run_end_count got %0d want 3", n_end); end
    checks++; if (tp !== 12'h001) begin errors++; $display("FAIL run_nogap got %h want 001", tp); end
`ifdef AGC_TPSEQ_MCT_COUNT_EN
    checks++; if (mct_count !== 16'd4) begin errors++; $display("FAIL run_count got %0d want 4", mct_count); end
`endif
  endtask

  task automatic test_mstp_stop();
    logic [11:0] exp_tp;
    for (int c = 1; c <= 24; c++) begin
      if (c == 9) mstp = 1'b1;
      exp_tp = 12'h001 << ((c - 1) / 2);
      checks++; if (tp !== exp_tp) begin errors++; $display("FAIL mstp_tp c=%0d got %h want %h", c, tp, exp_tp); end
      checks++; if (mct_end !== (c == 24)) begin errors++; $display("FAIL mstp_end c=%0d got %b", c, mct_end); end
      tick();
    end
    checks++; if (tp !== 12'h000) begin errors++; $display("FAIL mstp_tp_off got %h want 000", tp); end
    checks++; if (stopped !== 1'b1) begin errors++; $display("FAIL mstp_stopped got %b want 1", stopped); end
    checks++; if (mct_end !== 1'b0) begin errors++; $display("FAIL mstp_end_off got %b want 0", mct_end); end
`ifdef AGC_TPSEQ_MCT_COUNT_EN
    checks++; if (mct_count !== 16'd5) begin errors++; $display("FAIL mstp_count got %0d want 5", mct_count); end
`endif
  endtask

  task automatic test_single_step();
    logic [11:0] exp_tp;
    repeat (2) tick();
    checks++; if (stopped !== 1'b1 || tp !== 12'h000) begin errors++; $display("FAIL step_idle got stopped=%b tp=%h want 1/000", stopped, tp); end
    step_req = 1'b1;
    tick();
    step_req = 1'b0;
    checks++; if (stopped !== 1'b0) begin errors++; $display("FAIL step_stopped got %b want 0", stopped); end
    for (int c = 1; c <= 24; c++) begin
      if (c == 5) step_req = 1'b1;
      if (c == 6) step_req = 1'b0;
      exp_tp = 12'h001 << ((c - 1) / 2);
      checks++; if (tp !== exp_tp) begin errors++; $display("FAIL step_tp c=%0d got %h want %h", c, tp, exp_tp); end
      checks++; if (mct_end !== (c == 24)) begin errors++; $display("FAIL step_end c=%0d got %b", c, mct_end); end
      tick();
    end
    checks++; if (tp !== 12'h000 || stopped !== 1'b1) begin errors++; $display("FAIL step_return got tp=%h stopped=%b want 000/1", tp, stopped); end
    repeat (3) tick();
    checks++; if (tp !== 12'h000 || stopped !== 1'b1) begin errors++; $display("FAIL step_dropped got tp=%h stopped=%b want 000/1", tp, stopped); end
`ifdef AGC_TPSEQ_MCT_COUNT_EN
    checks++; if (mct_count !== 16'd6) begin errors++; $display("FAIL step_count got %0d want 6", mct_count); end
`endif
  endtask

  task automatic test_run_priority();
    logic [11:0] exp_tp;
    mstp = 1'b0;
    step_req = 1'b1;
    tick();
    step_req = 1'b0;
    for (int c = 1; c <= 24; c++) begin
      exp_tp = 12'h001 << ((c - 1) / 2);
      checks++; if (tp !== exp_tp) begin errors++; $display("FAIL prio_tp c=%0d got %h want %h", c, tp, exp_tp); end
      tick();
    end
    checks++; if (tp !== 12'h001 || stopped !== 1'b0) begin errors++; $display("FAIL prio_run got tp=%h stopped=%b want 001/0", tp, stopped); end
  endtask

  task automatic test_reset_mid_mct();
    int n;
    repeat (12) tick();
    checks++; if (tp !== 12'h040) begin errors++; $display("FAIL mid_t07 got %h want 040", tp); end
    rst = 1'b0;
    tick();
    checks++; if (tp !== 12'h000) begin errors++; $display("FAIL mid_tp got %h want 000", tp); end
    checks++; if (gate_rst !== 1'b1) begin errors++; $display("FAIL mid_gate_rst got %b want 1", gate_rst); end
    checks++; if (mct_end !== 1'b0) begin errors++; $display("FAIL mid_end got %b want 0", mct_end); end
`ifdef AGC_TPSEQ_MCT_COUNT_EN
    checks++; if (mct_count !== 16'd0) begin errors++; $display("FAIL mid_count got %0d want 0", mct_count); end
`endif
    rst = 1'b1;
    n = 1;
    for (int i = 0; i < 40; i++) begin
      tick();
      if (gate_rst === 1'b1) n++;
      else break;
    end
    checks++; if (n !== 16) begin errors++; $display("FAIL mid_hold_len got %0d want 16", n); end
    checks++; if (tp !== 12'h001) begin errors++; $display("FAIL mid_restart got %h want 001", tp); end
  endtask

  task automatic test_param_sweep();
    int n;
    logic [3:0] exp_tp;
    checks++; if (gate_rst_b !== 1'b1 || tp_b !== 4'h0) begin errors++; $display("FAIL sweep_reset got gate=%b tp=%h want 1/0", gate_rst_b, tp_b); end
    run_en_b = 1'b1;
    rst_b = 1'b1;
    n = 1;
    for (int i = 0; i < 10; i++) begin
      tick();
      if (gate_rst_b === 1'b1) n++;
      else break;
    end
    checks++; if (n !== 1) begin errors++; $display("FAIL sweep_hold_len got %0d want 1", n); end
    for (int k = 0; k < 8; k++) begin
      exp_tp = 4'h1 << (k % 4);
      checks++; if (tp_b !== exp_tp || !$onehot(tp_b)) begin errors++; $display("FAIL sweep_tp k=%0d got %h want %h", k, tp_b, exp_tp); end
      checks++; if (mct_end_b !== ((k % 4) == 3)) begin errors++; $display("FAIL sweep_end k=%0d got %b", k, mct_end_b); end
      tick();
    end
  endtask

  initial begin
    rst = 1'b0; run_en = 1'b1; mstp = 1'b0; step_req = 1'b0;
    rst_b = 1'b0; run_en_b = 1'b0; mstp_b = 1'b0; step_req_b = 1'b0;
    test_reset();
    test_hold_release();
    test_free_run();
    test_mstp_stop();
    test_single_step();
    test_run_priority();
    test_reset_mid_mct();
    test_param_sweep();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
